// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the load/store unit, the arbiter and the SRAM.
// The master side is the arbiter; the slave side is everything around it.
interface mem_port_arbiter_if;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ack;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_wren;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_ack;
  logic [31:0] o_ls_rdata;
  logic        o_sram_req;
  logic        o_sram_wren;
  logic [31:0] o_sram_addr;
  logic [31:0] o_sram_wdata;
  logic [3:0]  o_sram_bmask;
  logic        i_sram_ack;
  logic [31:0] i_sram_rdata;
  logic        o_err;
  logic        o_busy;

  modport master (
    input  i_if_req, i_if_addr, i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
           i_sram_ack, i_sram_rdata,
    output o_if_ack, o_if_rdata, o_ls_ack, o_ls_rdata, o_sram_req, o_sram_wren,
           o_sram_addr, o_sram_wdata, o_sram_bmask, o_err, o_busy
  );

  modport slave (
    output i_if_req, i_if_addr, i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
           i_sram_ack, i_sram_rdata,
    input  o_if_ack, o_if_rdata, o_ls_ack, o_ls_rdata, o_sram_req, o_sram_wren,
           o_sram_addr, o_sram_wdata, o_sram_bmask, o_err, o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM port between instruction fetch and load/store, alternating on contention,
// with a per-transaction wait timeout that completes the request with o_err set.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic          i_clk,
  input logic          i_reset,
  mem_port_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_ls;   // 0 = fetch was granted last
  logic        grant_ls;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [7:0]  wait_cnt;
  logic        sram_wren, busy, timeout, pick_ls, grant;
  logic [31:0] sram_addr, sram_wdata;
  logic [3:0]  sram_bmask;

  always_comb begin
    busy    = (state == BUSY_IF) || (state == BUSY_LS);
    timeout = (wait_cnt == 8'(TIMEOUT - 1));
    pick_ls = bus.i_ls_req && (!bus.i_if_req || !last_ls);
    grant   = (state == IDLE) && (bus.i_if_req || bus.i_ls_req);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = pick_ls ? BUSY_LS : BUSY_IF;
      BUSY_IF,
      BUSY_LS: if (bus.i_sram_ack || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      last_ls    <= 1'b0;
      grant_ls   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      wait_cnt   <= '0;
      sram_wren  <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_bmask <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        grant_ls   <= pick_ls;
        last_ls    <= pick_ls;
        wait_cnt   <= '0;
        sram_addr  <= pick_ls ? bus.i_ls_addr : bus.i_if_addr;
        sram_wdata <= pick_ls ? bus.i_ls_wdata : '0;
        sram_wren  <= pick_ls && bus.i_ls_wren;
        sram_bmask <= (pick_ls && bus.i_ls_wren) ? bus.i_ls_bmask : 4'hF;
      end else if (busy) begin
        // An ack coinciding with the timeout still counts as a clean completion.
        if (bus.i_sram_ack) begin
          rdata_q <= sram_wren ? '0 : bus.i_sram_rdata;
          err_q   <= 1'b0;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
    end
  end

  always_comb begin
    bus.o_sram_req   = busy;
    bus.o_sram_wren  = sram_wren;
    bus.o_sram_addr  = sram_addr;
    bus.o_sram_wdata = sram_wdata;
    bus.o_sram_bmask = sram_bmask;
    bus.o_if_ack     = (state == RESP) && !grant_ls;
    bus.o_ls_ack     = (state == RESP) && grant_ls;
    bus.o_if_rdata   = bus.o_if_ack ? rdata_q : '0;
    bus.o_ls_rdata   = bus.o_ls_ack ? rdata_q : '0;
    bus.o_err        = (state == RESP) && err_q;
    bus.o_busy       = (state != IDLE);
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with TIMEOUT=4; inputs change and outputs are
// checked on the falling edge so each step covers exactly one rising edge.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  mem_port_arbiter_if bus ();
  mem_port_arbiter #(.TIMEOUT(4)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic expect_ls;
    int   nacks;

    rst = 1'b1;
    bus.i_if_req = 0; bus.i_if_addr = 0; bus.i_ls_req = 0; bus.i_ls_wren = 0;
    bus.i_ls_addr = 0; bus.i_ls_wdata = 0; bus.i_ls_bmask = 0;
    bus.i_sram_ack = 0; bus.i_sram_rdata = 0;
    step(); step();
    check("rst_busy",  bus.o_busy, 0);
    check("rst_sreq",  bus.o_sram_req, 0);
    check("rst_addr",  bus.o_sram_addr, 0);
    check("rst_bmask", bus.o_sram_bmask, 0);
    check("rst_acks",  {bus.o_if_ack, bus.o_ls_ack, bus.o_err}, 0);
    rst = 1'b0;

    // Fetch with one-cycle SRAM latency
    bus.i_if_req = 1; bus.i_if_addr = 32'h0000_0010;
    step();
    check("if_sreq",  bus.o_sram_req, 1);
    check("if_addr",  bus.o_sram_addr, 32'h0000_0010);
    check("if_wren",  bus.o_sram_wren, 0);
    check("if_bmask", bus.o_sram_bmask, 4'hF);
    check("if_busy",  bus.o_busy, 1);
    bus.i_sram_ack = 1; bus.i_sram_rdata = 32'h0000_0093;
    step();
    check("if_ack",   bus.o_if_ack, 1);
    check("if_rdata", bus.o_if_rdata, 32'h0000_0093);
    check("if_err",   bus.o_err, 0);
    check("if_lsack", bus.o_ls_ack, 0);
    check("if_sreq0", bus.o_sram_req, 0);
    bus.i_if_req = 0; bus.i_sram_ack = 0;
    step();
    check("if_idle",  bus.o_busy, 0);

    // Store; SRAM rdata is nonzero to show stores return 0
    bus.i_ls_req = 1; bus.i_ls_wren = 1; bus.i_ls_addr = 32'h0000_7000;
    bus.i_ls_wdata = 32'hDEAD_BEEF; bus.i_ls_bmask = 4'b0011;
    step();
    check("st_sreq",  bus.o_sram_req, 1);
    check("st_wren",  bus.o_sram_wren, 1);
    check("st_addr",  bus.o_sram_addr, 32'h0000_7000);
    check("st_wdata", bus.o_sram_wdata, 32'hDEAD_BEEF);
    check("st_bmask", bus.o_sram_bmask, 4'b0011);
    bus.i_sram_ack = 1; bus.i_sram_rdata = 32'h1234_5678;
    step();
    check("st_ack",   bus.o_ls_ack, 1);
    check("st_rdata", bus.o_ls_rdata, 0);
    check("st_ifack", bus.o_if_ack, 0);
    bus.i_ls_req = 0; bus.i_ls_wren = 0; bus.i_sram_ack = 0;
    step();

    // Stray SRAM ack while idle
    bus.i_sram_ack = 1;
    step();
    check("late_busy", bus.o_busy, 0);
    check("late_acks", {bus.o_if_ack, bus.o_ls_ack, bus.o_sram_req}, 0);
    step();
    check("late_busy2", bus.o_busy, 0);
    bus.i_sram_ack = 0;

    // Timeout on a load: four request cycles then an error completion
    bus.i_ls_req = 1; bus.i_ls_addr = 32'h0000_0100; bus.i_ls_bmask = 4'b0101;
    bus.i_sram_rdata = 32'hFFFF_FFFF;
    step();
    for (int k = 0; k < 4; k++) begin
      check("to_sreq",  bus.o_sram_req, 1);
      check("to_addr",  bus.o_sram_addr, 32'h0000_0100);
      check("to_bmask", bus.o_sram_bmask, 4'hF);
      check("to_noack", bus.o_ls_ack, 0);
      step();
    end
    check("to_ack",   bus.o_ls_ack, 1);
    check("to_err",   bus.o_err, 1);
    check("to_rdata", bus.o_ls_rdata, 0);
    check("to_sreq0", bus.o_sram_req, 0);
    bus.i_ls_req = 0;
    step();

    // Ack in the last allowed cycle is a normal completion
    bus.i_ls_req = 1; bus.i_sram_rdata = 32'h5555_AAAA;
    step(); step(); step();
    check("edge_noack", bus.o_ls_ack, 0);
    check("edge_sreq",  bus.o_sram_req, 1);
    step();
    bus.i_sram_ack = 1;
    step();
    check("edge_ack",   bus.o_ls_ack, 1);
    check("edge_err",   bus.o_err, 0);
    check("edge_rdata", bus.o_ls_rdata, 32'h5555_AAAA);
    bus.i_ls_req = 0; bus.i_sram_ack = 0;
    step();

    // Reset in BUSY_LS together with an SRAM ack
    bus.i_ls_req = 1; bus.i_ls_addr = 32'h0000_0200;
    step();
    check("rb_sreq", bus.o_sram_req, 1);
    rst = 1; bus.i_sram_ack = 1;
    step();
    check("rb_sreq0", bus.o_sram_req, 0);
    check("rb_noack", bus.o_ls_ack, 0);
    check("rb_idle",  bus.o_busy, 0);
    rst = 0; bus.i_ls_req = 0; bus.i_sram_ack = 0;
    step();
    check("rb_noack2", {bus.o_ls_ack, bus.o_if_ack}, 0);

    // Contention after reset: LSU first, then strict alternation
    bus.i_if_req = 1; bus.i_if_addr = 32'h0000_0300;
    bus.i_ls_req = 1; bus.i_ls_wren = 0; bus.i_ls_addr = 32'h0000_0400;
    bus.i_sram_ack = 1; bus.i_sram_rdata = 32'hA5A5_0000;
    expect_ls = 1'b1;
    nacks = 0;
    for (int c = 0; c < 20 && nacks < 4; c++) begin
      step();
      if (bus.o_if_ack || bus.o_ls_ack) begin
        check("ct_excl",  bus.o_if_ack & bus.o_ls_ack, 0);
        check("ct_order", bus.o_ls_ack, expect_ls);
        check("ct_rdata", expect_ls ? bus.o_ls_rdata : bus.o_if_rdata, 32'hA5A5_0000);
        expect_ls = ~expect_ls;
        nacks++;
      end
    end
    check("ct_count", nacks, 4);
    bus.i_if_req = 0; bus.i_ls_req = 0; bus.i_sram_ack = 0;
    step(); step();
    check("ct_idle", bus.o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: cycles (1..255) o_sram_req may stay high without i_sram_ack before the transaction is aborted.
REQ-002 i_clk  in  1  the only clock; all state updates on its rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_if_req  in  1  fetch request; held high with i_if_addr stable until o_if_ack.
REQ-005 i_if_addr  in  32  fetch word address.
REQ-006 o_if_ack  out  1  one-cycle fetch completion pulse.
REQ-007 o_if_rdata  out  32  fetched instruction, valid while o_if_ack=1.
REQ-008 i_ls_req  in  1  load/store request; held high with its qualifiers stable until o_ls_ack.
REQ-009 i_ls_wren  in  1  1 = store, 0 = load.
REQ-010 i_ls_addr / i_ls_wdata  in  32 / 32  LSU address and store data.
REQ-011 i_ls_bmask  in  4  byte-lane enables for stores.
REQ-012 o_ls_ack  out  1  one-cycle LSU completion pulse.
REQ-013 o_ls_rdata  out  32  load data, valid while o_ls_ack=1; 0 for stores.
REQ-014 o_sram_req / o_sram_wren  out  1 / 1  memory request and write enable.
REQ-015 o_sram_addr / o_sram_wdata  out  32 / 32  registered memory address and write data.
REQ-016 o_sram_bmask  out  4  byte enables; 4'b1111 for fetch and loads.
REQ-017 i_sram_ack / i_sram_rdata  in  1 / 32  memory completion and read data, sampled together.
REQ-018 o_err  out  1  high with the ack pulse of a timed-out transaction.
REQ-019 o_busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states are IDLE, BUSY_IF, BUSY_LS, and RESP; o_busy=(state!=IDLE).
REQ-021 IDLE, only i_if_req: go to BUSY_IF and latch i_if_addr into o_sram_addr, with o_sram_wren=0 and bmask=1111.
REQ-022 IDLE, only i_ls_req: go to BUSY_LS and latch addr/wdata/wren/bmask.
REQ-023 IDLE, both requests: grant the requester not granted last (last_grant flag, reset value IF, so LSU wins first); the loser stays pending.
REQ-024 o_sram_req shall be high exactly in BUSY_IF/BUSY_LS, rising one cycle after the granting IDLE cycle.
REQ-025 In BUSY_*, i_sram_ack=1 shall capture rdata (0 for stores), drop o_sram_req next edge, and go to RESP.
REQ-026 RESP lasts one cycle: the granted requester's ack=1 and rdata valid; the other ack=0; then IDLE.
REQ-027 Requester req high in the cycle after its ack is a new request.
REQ-028 Minimum latency is req seen in cycle N -> ack in cycle N+2 when i_sram_ack arrives in cycle N+1; throughput is one transaction per 3 cycles.
REQ-029 An 8-bit wait counter clears on grant and increments each BUSY cycle without ack.
REQ-030 When the wait counter reaches TIMEOUT-1 without ack, the next edge shall drop o_sram_req, go to RESP with rdata=0 and o_err=1.
REQ-031 i_sram_ack outside BUSY_* is ignored; ack and timeout in the same cycle counts as a normal completion (o_err=0).
REQ-032 Requests arriving in non-IDLE states wait; no request is dropped; the ack pulses are mutually exclusive.
REQ-033 o_sram_addr/wdata/wren/bmask shall be constant throughout a BUSY state.

Reset
REQ-034 On i_clk edge with i_reset=1: state=IDLE, last_grant=IF, counter=0, all outputs 0 (o_sram_bmask=0000).
REQ-035 Reset mid-transaction abandons it: no ack is issued and o_sram_req=0 the next cycle; reset dominates i_sram_ack.

Verification
REQ-036 Fetch: if_req, addr=0x0000_0010, sram_ack one cycle later with rdata=0x0000_0093 -> o_if_ack=1 and o_if_rdata=0x0000_0093 two cycles after req; o_err=0.
REQ-037 Store: ls_req, wren=1, addr=0x0000_7000, wdata=0xDEAD_BEEF, bmask=0011 -> o_sram_* carry those values; o_ls_ack with o_ls_rdata=0.
REQ-038 Contention: both requests held continuously -> grants alternate LS, IF, LS, IF; no consecutive acks to the same requester.
REQ-039 Timeout: TIMEOUT=4, sram_ack never asserted -> o_sram_req high for 4 cycles, then o_ls_ack=1, o_err=1, and rdata=0.
REQ-040 Reset in BUSY_LS with sram_ack in the same cycle -> no ack, state IDLE, and o_sram_req=0 the next cycle.
REQ-041 Late ack: i_sram_ack pulsed while IDLE -> no ack output and no state change.
